// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field layout and exception codes.
package cp0_exc_ctrl_pkg;

  typedef enum logic [4:0] {
    CP0_SR    = 5'd12,
    CP0_CAUSE = 5'd13,
    CP0_EPC   = 5'd14,
    CP0_PRID  = 5'd15
  } cp0_reg_e;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int unsigned SR_IM_LO  = 10;
  localparam int unsigned SR_IM_HI  = 15;
  localparam int unsigned SR_EXL    = 1;
  localparam int unsigned SR_IE     = 0;
  localparam int unsigned CAUSE_BD  = 31;

endpackage

// File: rtl/cp0_int_arbiter.sv
// Combinational interrupt/exception arbiter; interrupts win over synchronous exceptions.
module cp0_int_arbiter
  import cp0_exc_ctrl_pkg::*;
(
  input  logic       i_ie,
  input  logic       i_exl,
  input  logic [5:0] i_im,
  input  logic [5:0] i_hwint,
  input  logic [4:0] i_exc_code,
  output logic       o_int_req,
  output logic       o_exc_req,
  output logic [4:0] o_exc_code
);

  always_comb begin
    o_int_req  = i_ie & ~i_exl & (|(i_hwint & i_im));
    o_exc_req  = ~i_exl & (i_exc_code != 5'd0);
    o_exc_code = o_int_req ? EXC_INT : i_exc_code;
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// M-stage CP0 register file (SR/Cause/EPC/PRId) with exception/interrupt request generation.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_2021,
  parameter logic [31:0] KERNEL_PC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_PC,
  input  logic [4:0]  M_exc_code,
  input  logic        M_BD,
  input  logic [5:0]  HWInt,
  input  logic [4:0]  cp0_addr,
  input  logic        cp0_we,
  input  logic [31:0] cp0_din,
  input  logic        eret,
  output logic [31:0] cp0_dout,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc,
  output logic        int_exc_req
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic [4:0]  w_exc_code;
  logic [31:0] w_epc_src;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  cp0_int_arbiter u_arb (
    .i_ie       (r_ie),
    .i_exl      (r_exl),
    .i_im       (r_im),
    .i_hwint    (HWInt),
    .i_exc_code (M_exc_code),
    .o_int_req  (w_int_req),
    .o_exc_req  (w_exc_req),
    .o_exc_code (w_exc_code)
  );

  always_comb begin
    int_exc_req = w_int_req | w_exc_req;
    w_epc_src   = M_BD ? (M_PC - 32'd4) : M_PC;
    handler_pc  = KERNEL_PC;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      r_ip <= HWInt;
      // A flush request takes precedence: the mtc0/eret in M is being squashed.
      if (int_exc_req) begin
        r_exl      <= 1'b1;
        r_exc_code <= w_exc_code;
        r_bd       <= M_BD;
        r_epc      <= {w_epc_src[31:2], 2'b00};
      end else if (eret) begin
        r_exl <= 1'b0;
      end else if (cp0_we) begin
        case (cp0_addr)
          CP0_SR: begin
            r_im  <= cp0_din[SR_IM_HI:SR_IM_LO];
            r_exl <= cp0_din[SR_EXL];
            r_ie  <= cp0_din[SR_IE];
          end
          CP0_EPC: r_epc <= {cp0_din[31:2], 2'b00};
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_sr    = {16'h0000, r_im, 8'h00, r_exl, r_ie};
    w_cause = {r_bd, 15'h0000, r_ip, 3'b000, r_exc_code, 2'b00};
    case (cp0_addr)
      CP0_SR:    cp0_dout = w_sr;
      CP0_CAUSE: cp0_dout = w_cause;
      CP0_EPC:   cp0_dout = r_epc;
      CP0_PRID:  cp0_dout = PRID_VALUE;
      default:   cp0_dout = '0;
    endcase
    epc_out = (cp0_we && cp0_addr == CP0_EPC) ? {cp0_din[31:2], 2'b00} : r_epc;
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: directed test-plan sequences followed by random traffic.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_PC;
  logic [4:0]  M_exc_code;
  logic        M_BD;
  logic [5:0]  HWInt;
  logic [4:0]  cp0_addr;
  logic        cp0_we;
  logic [31:0] cp0_din;
  logic        eret;
  logic [31:0] cp0_dout;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;
  logic        int_exc_req;

  localparam logic [31:0] PRID = 32'h0000_2021;
  localparam logic [31:0] KPC  = 32'h0000_4180;

  cp0_exc_ctrl #(.PRID_VALUE(PRID), .KERNEL_PC(KPC)) dut (
    .clk        (clk),
    .reset      (reset),
    .M_PC       (M_PC),
    .M_exc_code (M_exc_code),
    .M_BD       (M_BD),
    .HWInt      (HWInt),
    .cp0_addr   (cp0_addr),
    .cp0_we     (cp0_we),
    .cp0_din    (cp0_din),
    .eret       (eret),
    .cp0_dout   (cp0_dout),
    .epc_out    (epc_out),
    .handler_pc (handler_pc),
    .int_exc_req(int_exc_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] dout;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Architectural model: whole 32-bit register words as software would see them.
  logic [31:0] m_sr, m_cause, m_epc;

  task automatic step(input logic rst, input logic [31:0] pc, input logic [4:0] code,
                      input logic bd, input logic [5:0] hw, input logic [4:0] addr,
                      input logic we, input logic [31:0] din, input logic er);
    exp_t e;
    logic ie, exl, ireq, ereq;
    logic [5:0] im;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    reset = rst; M_PC = pc; M_exc_code = code; M_BD = bd; HWInt = hw;
    cp0_addr = addr; cp0_we = we; cp0_din = din; eret = er;
    ie   = m_sr[0];
    exl  = m_sr[1];
    im   = m_sr[15:10];
    ireq = ie && !exl && ((hw & im) != 6'd0);
    ereq = !exl && (code != 5'd0);
    e.req = ireq || ereq;
    case (addr)
      5'd12:   e.dout = m_sr;
      5'd13:   e.dout = m_cause;
      5'd14:   e.dout = m_epc;
      5'd15:   e.dout = PRID;
      default: e.dout = 32'd0;
    endcase
    e.epc = (we && addr == 5'd14) ? (din & 32'hFFFF_FFFC) : m_epc;
    exp_q.push_back(e);
    if (rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause[15:10] = hw;
      if (e.req) begin
        m_sr[1] = 1'b1;
        m_cause[31]  = bd;
        m_cause[6:2] = ireq ? 5'd0 : code;
        tgt = bd ? pc - 32'd4 : pc;
        m_epc = tgt & 32'hFFFF_FFFC;
      end else if (er) begin
        m_sr[1] = 1'b0;
      end else if (we) begin
        if (addr == 5'd12) m_sr = din & 32'h0000_FC03;
        else if (addr == 5'd14) m_epc = din & 32'hFFFF_FFFC;
      end
    end
  endtask

  // Plain read/idle cycle: no exception, no write.
  task automatic rd(input logic [4:0] addr, input logic [5:0] hw);
    step(1'b0, 32'h0000_3000, 5'd0, 1'b0, hw, addr, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] din);
    step(1'b0, 32'h0000_3000, 5'd0, 1'b0, 6'd0, addr, 1'b1, din, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total += 4;
      if (int_exc_req !== e.req) begin
        bad++;
        $display("FAIL int_exc_req: got %0b want %0b", int_exc_req, e.req);
      end
      if (cp0_dout !== e.dout) begin
        bad++;
        $display("FAIL cp0_dout addr=%0d: got %h want %h", cp0_addr, cp0_dout, e.dout);
      end
      if (epc_out !== e.epc) begin
        bad++;
        $display("FAIL epc_out: got %h want %h", epc_out, e.epc);
      end
      if (handler_pc !== KPC) begin
        bad++;
        $display("FAIL handler_pc: got %h want %h", handler_pc, KPC);
      end
    end
  end

  initial begin
    reset = 1'b1; M_PC = '0; M_exc_code = '0; M_BD = 1'b0; HWInt = '0;
    cp0_addr = '0; cp0_we = 1'b0; cp0_din = '0; eret = 1'b0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    repeat (3) @(posedge clk);
    // reset state
    rd(5'd12, 6'd0); rd(5'd13, 6'd0); rd(5'd14, 6'd0);
    // masked interrupt taken
    wr(5'd12, 32'h0000_0401);
    step(1'b0, 32'h0000_3010, 5'd0, 1'b0, 6'b000001, 5'd12, 1'b0, 32'd0, 1'b0);
    rd(5'd13, 6'b000001); rd(5'd12, 6'b000001); rd(5'd14, 6'b000001);
    // EXL masking: exception and interrupt ignored
    step(1'b0, 32'h0000_3050, 5'd4, 1'b0, 6'b000001, 5'd13, 1'b0, 32'd0, 1'b0);
    // eret, then interrupt fires again
    step(1'b0, 32'h0000_3054, 5'd0, 1'b0, 6'b000001, 5'd14, 1'b0, 32'd0, 1'b1);
    rd(5'd13, 6'b000001);
    step(1'b0, 32'h0, 5'd0, 1'b0, 6'd0, 5'd12, 1'b0, 32'd0, 1'b1);
    // exception in delay slot with SR=0
    wr(5'd12, 32'h0);
    step(1'b0, 32'h0000_3024, 5'd12, 1'b1, 6'd0, 5'd13, 1'b0, 32'd0, 1'b0);
    rd(5'd13, 6'd0); rd(5'd14, 6'd0);
    step(1'b0, 32'h0, 5'd0, 1'b0, 6'd0, 5'd12, 1'b0, 32'd0, 1'b1);
    // priority: interrupt beats RI
    wr(5'd12, 32'h0000_0401);
    step(1'b0, 32'h0000_3100, 5'd10, 1'b0, 6'b000001, 5'd13, 1'b1, 32'h0, 1'b1);
    rd(5'd13, 6'd0); rd(5'd14, 6'd0);
    // EPC bypass (mtc0 during EXL)
    wr(5'd14, 32'h0000_3107); rd(5'd14, 6'd0);
    step(1'b0, 32'h0, 5'd0, 1'b0, 6'd0, 5'd14, 1'b0, 32'd0, 1'b1);
    // read-only / unused registers
    wr(5'd15, 32'hFFFF_FFFF); wr(5'd13, 32'hFFFF_FFFF); wr(5'd7, 32'h1234_5678);
    rd(5'd15, 6'd0); rd(5'd13, 6'd0); rd(5'd7, 6'd0);
    // BD wrap at PC=0, then reset mid-exception
    step(1'b0, 32'h0, 5'd5, 1'b1, 6'd0, 5'd14, 1'b0, 32'd0, 1'b0);
    rd(5'd14, 6'd0);
    step(1'b1, 32'h0, 5'd0, 1'b0, 6'd0, 5'd12, 1'b0, 32'd0, 1'b0);
    rd(5'd12, 6'd0); rd(5'd14, 6'd0);
    // random traffic
    for (int unsigned i = 0; i < 600; i++) begin
      logic [4:0] a, c;
      logic w, er, rs;
      logic [31:0] d;
      a  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      c  = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      w  = ($urandom_range(0, 3) == 0);
      er = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 99) == 0);
      d  = $urandom;
      if (w && a == 5'd12 && $urandom_range(0, 1) == 1) d[1] = 1'b0;
      step(rs, $urandom, c, 1'($urandom), 6'($urandom), a, w, d, er);
    end
    begin : drain
      int unsigned n;
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
        @(posedge clk);
        n++;
      end
      if (exp_q.size() > 0) begin
        total++;
        bad++;
        $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
